// File: rtl/decode_stage.sv
// Decode stage: register file with write-through bypass, R/I/J decode, and an
// output register backed by one skid entry. Held ops snoop writebacks so that
// their operands never go stale while they wait for the ALU.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_class,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [5:0]  out_func,
  output logic [25:0] out_target,
  output logic [31:0] out_pc,
  output logic [4:0]  out_dest,
  output logic [7:0]  illegal_cnt
);

  localparam logic [1:0] ClsR       = 2'b00;
  localparam logic [1:0] ClsI       = 2'b01;
  localparam logic [1:0] ClsJ       = 2'b10;
  localparam logic [1:0] ClsIllegal = 2'b11;

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpJ       = 6'b000010;
  localparam logic [5:0] OpAddi    = 6'b001000;
  localparam logic [5:0] OpSlti    = 6'b001010;
  localparam logic [5:0] Op1a      = 6'b011010;
  localparam logic [5:0] OpAndi    = 6'b001100;
  localparam logic [5:0] OpOri     = 6'b001101;

  // One buffered op. rs/rt and the snoop flags travel with it so a held op
  // can pick up later writebacks to its source registers.
  typedef struct packed {
    logic [1:0]  cls;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [5:0]  func;
    logic [25:0] target;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        snoop_rs;
    logic        snoop_rt;
  } op_t;

  // Replace operands whose source register is being written this cycle.
  function automatic op_t snoop(input op_t e, input logic en, input logic [4:0] a,
                                input logic [31:0] d);
    op_t r;
    r = e;
    if (en && a != 5'd0) begin
      if (e.snoop_rs && e.rs == a) r.op1 = d;
      if (e.snoop_rt && e.rt == a) r.op2 = d;
    end
    return r;
  endfunction

  logic [31:0] rf [32];
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  op_t         out_q, out_d, skid_q, skid_d;
  op_t         out_snp, skid_snp, dec;
  logic [7:0]  illegal_cnt_q, illegal_cnt_d;
  logic        accept, issue;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val;

  assign opcode = in_instr[31:26];
  assign rs     = in_instr[25:21];
  assign rt     = in_instr[20:16];
  assign rd     = in_instr[15:11];
  assign funct  = in_instr[5:0];
  assign imm    = in_instr[15:0];

  // r0 reads as zero; a same-cycle writeback is forwarded
  assign rs_val = (rs == 5'd0) ? 32'd0 :
                  (wb_en && wb_addr == rs) ? wb_data : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 :
                  (wb_en && wb_addr == rt) ? wb_data : rf[rt];

  assign in_ready = ~skid_valid_q & ~rst;
  assign accept   = in_valid & in_ready;
  assign issue    = out_valid_q & out_ready;

  assign out_snp  = snoop(out_q, wb_en, wb_addr, wb_data);
  assign skid_snp = snoop(skid_q, wb_en, wb_addr, wb_data);

  // Decode the incoming instruction into a buffer entry
  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.rs     = rs;
    dec.rt     = rt;
    dec.cls    = ClsIllegal;
    case (opcode)
      OpSpecial: begin
        case (funct)
          6'b100000, 6'b100010, 6'b100001, 6'b100011, 6'b100100,
          6'b100101, 6'b000000, 6'b000010, 6'b101010: begin
            dec.cls      = ClsR;
            dec.op1      = rs_val;
            dec.op2      = rt_val;
            dec.func     = funct;
            dec.dest     = rd;
            dec.snoop_rs = 1'b1;
            dec.snoop_rt = 1'b1;
          end
          default: ;
        endcase
      end
      OpAddi, Op1a, OpSlti: begin
        dec.cls      = ClsI;
        dec.op1      = rs_val;
        dec.op2      = {{16{imm[15]}}, imm};
        dec.func     = opcode;
        dec.dest     = rt;
        dec.snoop_rs = 1'b1;
      end
      OpAndi, OpOri: begin
        dec.cls      = ClsI;
        dec.op1      = rs_val;
        dec.op2      = {16'd0, imm};
        dec.func     = opcode;
        dec.dest     = rt;
        dec.snoop_rs = 1'b1;
      end
      OpJ: begin
        dec.cls    = ClsJ;
        dec.target = in_instr[25:0];
      end
      default: ;
    endcase
  end

  // Output/skid next state: fill the output when it empties, else park in skid
  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_snp;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_snp;
    if (!out_valid_q || issue) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_d        = skid_snp;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_d       = dec;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = dec;
    end
  end

  // Saturating count of accepted illegal instructions
  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (accept && dec.cls == ClsIllegal && illegal_cnt_q != 8'd255) begin
      illegal_cnt_d = illegal_cnt_q + 8'd1;
    end
  end

  // Pipeline state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_q         <= '0;
      skid_valid_q  <= 1'b0;
      skid_q        <= '0;
      illegal_cnt_q <= 8'd0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_q         <= out_d;
      skid_valid_q  <= skid_valid_d;
      skid_q        <= skid_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Register file; writes to r0 are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (wb_en && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_class   = out_q.cls;
  assign out_op1     = out_q.op1;
  assign out_op2     = out_q.op2;
  assign out_func    = out_q.func;
  assign out_target  = out_q.target;
  assign out_pc      = out_q.pc;
  assign out_dest    = out_q.dest;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic, checked each
// cycle against a queue-based reference model of the stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_class;
  logic [31:0] out_op1, out_op2, out_pc;
  logic [5:0]  out_func;
  logic [25:0] out_target;
  logic [4:0]  out_dest;
  logic [7:0]  illegal_cnt;

  decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_op1    (out_op1),
    .out_op2    (out_op2),
    .out_func   (out_func),
    .out_target (out_target),
    .out_pc     (out_pc),
    .out_dest   (out_dest),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cls;
    logic [31:0] op1, op2;
    logic [5:0]  func;
    logic [25:0] target;
    logic [31:0] pc;
    logic [4:0]  dest, rs, rt;
  } exp_op_t;

  exp_op_t     q[$];
  logic [31:0] regs [32];
  int          m_cnt;
  int          n_pass = 0;
  int          n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] rd_reg(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return regs[a];
  endfunction

  // Decode from the instruction-set rules
  function automatic exp_op_t decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_op_t o;
    logic [5:0] opc, fn;
    opc = ins[31:26];
    fn  = ins[5:0];
    o = '{cls: 2'b11, op1: 0, op2: 0, func: 0, target: 0, pc: pc, dest: 0,
          rs: ins[25:21], rt: ins[20:16]};
    if (opc == 6'd0 && fn inside {6'h20, 6'h22, 6'h21, 6'h23, 6'h24, 6'h25, 6'h00, 6'h02,
                                  6'h2a}) begin
      o.cls = 2'b00; o.op1 = rd_reg(o.rs); o.op2 = rd_reg(o.rt);
      o.func = fn; o.dest = ins[15:11];
    end else if (opc inside {6'h08, 6'h1a, 6'h0a}) begin
      o.cls = 2'b01; o.op1 = rd_reg(o.rs); o.op2 = 32'($signed(ins[15:0]));
      o.func = opc; o.dest = o.rt;
    end else if (opc inside {6'h0c, 6'h0d}) begin
      o.cls = 2'b01; o.op1 = rd_reg(o.rs); o.op2 = {16'd0, ins[15:0]};
      o.func = opc; o.dest = o.rt;
    end else if (opc == 6'h02) begin
      o.cls = 2'b10; o.target = ins[25:0];
    end
    return o;
  endfunction

  // Advance the model by one clock using the inputs about to be sampled
  task automatic model_update();
    exp_op_t n;
    bit acc, iss;
    if (rst) begin
      q.delete();
      foreach (regs[i]) regs[i] = 32'd0;
      m_cnt = 0;
      return;
    end
    acc = in_valid && q.size() < 2;
    iss = q.size() > 0 && out_ready;
    if (acc) n = decode(in_instr, in_pc);
    if (iss) void'(q.pop_front());
    if (wb_en && wb_addr != 5'd0) begin
      foreach (q[i]) begin
        if (q[i].cls inside {2'b00, 2'b01} && q[i].rs == wb_addr) q[i].op1 = wb_data;
        if (q[i].cls == 2'b00 && q[i].rt == wb_addr) q[i].op2 = wb_data;
      end
    end
    if (acc) begin
      q.push_back(n);
      if (n.cls == 2'b11 && m_cnt < 255) m_cnt++;
    end
    if (wb_en && wb_addr != 5'd0) regs[wb_addr] = wb_data;
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2 && !rst));
    check("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
    if (q.size() > 0) begin
      check("out_class", 32'(out_class), 32'(q[0].cls));
      check("out_op1", out_op1, q[0].op1);
      check("out_op2", out_op2, q[0].op2);
      check("out_func", 32'(out_func), 32'(q[0].func));
      check("out_target", 32'(out_target), 32'(q[0].target));
      check("out_pc", out_pc, q[0].pc);
      check("out_dest", 32'(out_dest), 32'(q[0].dest));
    end
  endtask

  // Called at a falling edge: check, drive, update model, run one cycle
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ordy, input logic r);
    compare_all();
    in_valid = v; in_instr = ins; in_pc = pc;
    wb_en = we; wb_addr = wa; wb_data = wd;
    out_ready = ordy; rst = r;
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] r_fn [9] = '{6'h20, 6'h22, 6'h21, 6'h23, 6'h24, 6'h25, 6'h00, 6'h02, 6'h2a};
    logic [5:0] i_op [5] = '{6'h08, 6'h1a, 6'h0a, 6'h0c, 6'h0d};
    logic [31:0] ins;
    int k;
    ins = $urandom;
    k = int'($urandom_range(0, 9));
    if (k <= 2) begin
      ins[31:26] = 6'd0; ins[5:0] = r_fn[$urandom_range(0, 8)];
    end else if (k <= 5) begin
      ins[31:26] = i_op[$urandom_range(0, 4)];
    end else if (k == 6) begin
      ins[31:26] = 6'h02;
    end else if (k == 7) begin
      ins[31:26] = 6'd0;
    end
    if (k != 6) begin
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
    end
    return ins;
  endfunction

  initial begin
    // Bring the DUT out of its unknown power-up state before checking
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_update();

    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);

    // sub r10,r8,r9 with r8=5, r9=3
    step(1'b0, 0, 0, 1'b1, 5'd8, 32'd5, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b1, 5'd9, 32'd3, 1'b1, 1'b0);
    step(1'b1, 32'h0109_5022, 32'h40, 1'b0, 0, 0, 1'b1, 1'b0);
    check("sub_valid", 32'(out_valid), 32'd1);
    check("sub_class", 32'(out_class), 32'd0);
    check("sub_op1", out_op1, 32'd5);
    check("sub_op2", out_op2, 32'd3);
    check("sub_func", 32'(out_func), 32'h22);
    check("sub_dest", 32'(out_dest), 32'd10);

    step(1'b1, 32'h2128_FFFF, 32'h44, 1'b0, 0, 0, 1'b1, 1'b0);
    check("addi_class", 32'(out_class), 32'd1);
    check("addi_op1", out_op1, 32'd3);
    check("addi_op2", out_op2, 32'hFFFF_FFFF);
    check("addi_func", 32'(out_func), 32'h08);
    check("addi_dest", 32'(out_dest), 32'd8);
    step(1'b1, 32'h3528_FFFF, 32'h48, 1'b0, 0, 0, 1'b1, 1'b0);
    check("ori_op2", out_op2, 32'h0000_FFFF);
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0);

    // Skid fill, back-pressure, then in-order drain with no bubble
    step(1'b1, 32'h0109_5022, 32'h100, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 32'h2128_FFFF, 32'h104, 1'b0, 0, 0, 1'b0, 1'b0);
    check("skid_full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 32'h3528_FFFF, 32'h108, 1'b0, 0, 0, 1'b0, 1'b0);
    check("held_pc", out_pc, 32'h100);
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0);
    check("drain1_valid", 32'(out_valid), 32'd1);
    check("drain1_pc", out_pc, 32'h104);
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0);
    check("drain2_valid", 32'(out_valid), 32'd0);

    // Snoop into a held op; a write to r0 must not disturb it
    step(1'b1, 32'h0109_5022, 32'h200, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 5'd8, 32'h1234, 1'b0, 1'b0);
    check("snoop_op1", out_op1, 32'h1234);
    step(1'b0, 0, 0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0);
    check("snoop_r0", out_op1, 32'h1234);
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0);

    // Illegal opcode 111111 saturates the counter
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 32'hFC00_0000 | (i & 32'h3FF_FFFF), 32'(i), 1'b0, 0, 0, 1'b1, 1'b0);
      check("ill_class", 32'(out_class), 32'd3);
      check("ill_dest", 32'(out_dest), 32'd0);
      check("ill_cnt", 32'(illegal_cnt), (i < 255) ? 32'(i + 1) : 32'd255);
    end
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0);

    // Reset with both buffers occupied
    step(1'b1, 32'hFC00_0000, 32'h300, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 32'hFC00_0000, 32'h304, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cnt", 32'(illegal_cnt), 32'd0);
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    step(1'b1, 32'h0109_5022, 32'h400, 1'b0, 0, 0, 1'b1, 1'b0);
    check("post_rst_op1", out_op1, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 199) == 0);
    end
    compare_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
